// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - display-value side and pin side signals of the 7-segment scan controller
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output en, value, dp_in, lz_blank,
        input  an, seg, dp, digit_idx, frame_done
    );

    modport slave (
        input  en, value, dp_in, lz_blank,
        output an, seg, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - multiplexed active-low 7-segment scanner with blanking gap and leading-zero suppression
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 200000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         reset,
    seg_scan_if.slave    bus
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(TICK_DIV + 1);
    localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_snap_q, val_snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic                    lz_snap_q, lz_snap_d;
    logic                    tick;
    logic                    fd_d, fd_q;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   an_d, an_q;
    logic [6:0]              seg_d, seg_q;
    logic                    dp_d, dp_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot tick: last clock of each TICK_DIV-long slot while scanning
    always_comb begin
        tick = (state_q != IDLE) && (cnt_q == CNT_W'(TICK_DIV));
    end

    // Next-state logic: slot counter, blanking counter, digit index and frame snapshot
    always_comb begin
        state_d    = state_q;
        cnt_d      = CNT_W'(1);
        bcnt_d     = bcnt_q;
        idx_d      = idx_q;
        val_snap_d = val_snap_q;
        dp_snap_d  = dp_snap_q;
        lz_snap_d  = lz_snap_q;
        fd_d       = 1'b0;

        if (state_q != IDLE && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d    = BLANK;
                    idx_d      = '0;
                    bcnt_d     = '0;
                    val_snap_d = bus.value;
                    dp_snap_d  = bus.dp_in;
                    lz_snap_d  = bus.lz_blank;
                end
            end
            BLANK: begin
                bcnt_d = bcnt_q + BCNT_W'(1);
                if (bcnt_q == BCNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (tick) begin
                    state_d = BLANK;
                    bcnt_d  = '0;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        // Frame boundary: the only point where a new value is taken
                        idx_d      = '0;
                        fd_d       = 1'b1;
                        val_snap_d = bus.value;
                        dp_snap_d  = bus.dp_in;
                        lz_snap_d  = bus.lz_blank;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling wins over everything and keeps the last snapshot
        if (!bus.en) begin
            state_d    = IDLE;
            idx_d      = '0;
            cnt_d      = CNT_W'(1);
            bcnt_d     = '0;
            fd_d       = 1'b0;
            val_snap_d = val_snap_q;
            dp_snap_d  = dp_snap_q;
            lz_snap_d  = lz_snap_q;
        end
    end

    // Leading-zero mask: digit k>=1 blanked when it and every higher nibble are zero
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (val_snap_d[4*k +: 4] == 4'h0);
            if (k != 0) begin
                blank_mask[k] = lz_snap_d && all_zero;
            end
        end
    end

    // Pin values for the upcoming state, so outputs move together with the state register
    always_comb begin
        nib  = val_snap_d[{idx_d, 2'b00} +: 4];
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == SHOW && !blank_mask[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = hex_to_seg(nib);
            dp_d        = ~dp_snap_d[idx_d];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_W'(1);
            bcnt_q     <= '0;
            idx_q      <= '0;
            val_snap_q <= '0;
            dp_snap_q  <= '0;
            lz_snap_q  <= 1'b0;
            fd_q       <= 1'b0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            idx_q      <= idx_d;
            val_snap_q <= val_snap_d;
            dp_snap_q  <= dp_snap_d;
            lz_snap_q  <= lz_snap_d;
            fd_q       <= fd_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller comparing runs of constant pin state
module tb_seg_scan_controller;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus();

    seg_scan_controller #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (10),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [14:0] t;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mon_on = 1'b0;
    int   run_no = 0;

    // len 0 means the run length is not checked
    task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                        input logic [1:0] idx, input logic fd, input int len);
        exp_t e;
        e.t   = {an, seg, dp, idx, fd};
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic dark(input logic [1:0] idx, input int len);
        push(4'hF, 7'h7F, 1'b1, idx, 1'b0, len);
    endtask

    task automatic frame_head();
        push(4'hF, 7'h7F, 1'b1, 2'd0, 1'b1, 1);
        dark(2'd0, 1);
    endtask

    task automatic lit_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dpx);
        push(4'hE, s0, dpx[0], 2'd0, 1'b0, 8);
        dark(2'd1, 2);
        push(4'hD, s1, dpx[1], 2'd1, 1'b0, 8);
        dark(2'd2, 2);
        push(4'hB, s2, dpx[2], 2'd2, 1'b0, 8);
        dark(2'd3, 2);
        push(4'h7, s3, dpx[3], 2'd3, 1'b0, 8);
    endtask

    task automatic check_run(input logic [14:0] t, input int len);
        exp_t e;
        checks++;
        run_no++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL run%0d unexpected: an=%h seg=%h dp=%b idx=%0d fd=%b len=%0d, none expected",
                     run_no, t[14:11], t[10:4], t[3], t[2:1], t[0], len);
        end else begin
            e = exp_q.pop_front();
            if (t !== e.t || (e.len != 0 && len != e.len)) begin
                fails++;
                $display("FAIL run%0d: got an=%h seg=%h dp=%b idx=%0d fd=%b len=%0d, expected an=%h seg=%h dp=%b idx=%0d fd=%b len=%0d",
                         run_no, t[14:11], t[10:4], t[3], t[2:1], t[0], len,
                         e.t[14:11], e.t[10:4], e.t[3], e.t[2:1], e.t[0], e.len);
            end
        end
    endtask

    // Monitor: each change of the pin tuple closes a run that is checked against the scoreboard
    initial begin
        logic [14:0] cur;
        logic [14:0] run_val;
        int          run_len;
        bit          have;
        have    = 1'b0;
        run_len = 0;
        run_val = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cur = {bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_done};
                if (!have) begin
                    run_val = cur;
                    run_len = 1;
                    have    = 1'b1;
                end else if (cur === run_val) begin
                    run_len++;
                end else begin
                    check_run(run_val, run_len);
                    run_val = cur;
                    run_len = 1;
                end
            end else begin
                have = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.lz_blank = 1'b0;

        dark(2'd0, 0);
        @(negedge clk);
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        lit_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);
        frame_head();
        lit_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);
        bus.value = 16'h1234;
        bus.en    = 1'b1;

        repeat (50) @(negedge clk);
        frame_head();
        lit_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b1111);
        bus.value = 16'hABCD;

        repeat (40) @(negedge clk);
        frame_head();
        push(4'hE, 7'h40, 1'b1, 2'd0, 1'b0, 8);
        dark(2'd1, 2);
        push(4'hD, 7'h78, 1'b1, 2'd1, 1'b0, 8);
        dark(2'd2, 10);
        dark(2'd3, 10);
        bus.value    = 16'h0070;
        bus.lz_blank = 1'b1;
        bus.dp_in    = 4'b0100;

        repeat (40) @(negedge clk);
        frame_head();
        push(4'hE, 7'h40, 1'b1, 2'd0, 1'b0, 8);
        dark(2'd1, 10);
        dark(2'd2, 10);
        dark(2'd3, 10);
        bus.value = 16'h0000;

        repeat (40) @(negedge clk);
        frame_head();
        lit_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1011);
        frame_head();
        push(4'hE, 7'h19, 1'b1, 2'd0, 1'b0, 8);
        dark(2'd1, 2);
        push(4'hD, 7'h30, 1'b1, 2'd1, 1'b0, 8);
        dark(2'd2, 2);
        bus.value    = 16'h1234;
        bus.lz_blank = 1'b0;

        repeat (95) @(negedge clk);
        push(4'hB, 7'h24, 1'b0, 2'd2, 1'b0, 3);
        bus.en = 1'b0;

        repeat (10) @(negedge clk);
        dark(2'd0, 12);
        push(4'hE, 7'h19, 1'b1, 2'd0, 1'b0, 8);
        dark(2'd1, 2);
        bus.en = 1'b1;

        repeat (15) @(negedge clk);
        push(4'hD, 7'h30, 1'b1, 2'd1, 1'b0, 3);
        dark(2'd0, 0);
        reset  = 1'b1;
        bus.en = 1'b0;

        repeat (2) @(negedge clk);
        reset = 1'b0;

        repeat (5) @(negedge clk);
        push(4'hE, 7'h12, 1'b1, 2'd0, 1'b0, 8);
        dark(2'd1, 2);
        bus.value = 16'h0005;
        bus.dp_in = 4'b0000;
        bus.en    = 1'b1;

        repeat (15) @(negedge clk);
        mon_on = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d runs left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
